multicycle_control: RTL and testbench
=====================================

# multicycle_control

Parametrised multi-cycle MIPS control unit, the successor to the single-cycle main decoder. Holds a state machine that sequences each instruction through fetch, decode, execute, memory and write-back cycles on a shared ALU and unified memory. Supports variable memory latency through a ready handshake with timeout trap. Sits between the instruction register opcode field and the datapath muxes and enables, and keeps a retired-instruction counter.

## Interface
- ALUOP_WIDTH, 4: width of ALUOp; the encodings below are zero-extended to this width (minimum 4).
- MEM_TIMEOUT, 15: maximum consecutive MemReady=0 cycles in a memory state before trapping; 0 disables the timeout.
- CNT_WIDTH, 32: width of InstrCount.

- Clk  in  1  clock; all state updates on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Opcode  in  6  Instruction[31:26] from the instruction register.
- MemReady  in  1  memory completes the current read/write this cycle.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  out  1 each  datapath strobes and mux selects.
- ALUSrcB  out  2  00 reg B, 01 constant 4, 10 sign-extended immediate, 11 immediate<<2.
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- ALUOp  out  ALUOP_WIDTH  0000 add, 0001 sub, 0010 use funct, 0100 addi, 0101 addiu, 0110 andi, 0111 ori.
- State  out  4  current state encoding, for debug.
- Trap  out  1  illegal opcode or memory timeout; sticky.
- InstrCount  out  CNT_WIDTH  retired instructions, wraps modulo 2^CNT_WIDTH.

## Operation
- Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, J 000010, ADDI 001000, ADDIU 001001, ANDI 001100, ORI 001101. Any other opcode is illegal.
- States: FETCH=0, DECODE=1, MEMADDR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11, TRAP=12.
- FETCH outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSource=00.
  - If MemReady=1: IRWrite=1 and PCWrite=1; move to DECODE. Otherwise stay in FETCH.
- DECODE outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=add.
  - Next state by opcode: LW/SW→MEMADDR, RTYPE→EXEC, BEQ→BRANCH, J→JUMP, I-type ALU→IEXEC, illegal→TRAP.
- MEMADDR outputs: ALUSrcA=1, ALUSrcB=10, add. Next state MEMRD for LW, MEMWR for SW.
- MEMRD outputs: MemRead=1, IorD=1. Wait on MemReady, then go to MEMWB.
- MEMWB outputs: RegWrite=1, MemtoReg=1, RegDst=0.
- MEMWR outputs: MemWrite=1, IorD=1. Wait on MemReady.
- EXEC outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=0010. Next state RWB.
- RWB outputs: RegWrite=1, RegDst=1, MemtoReg=0.
- BRANCH outputs: ALUSrcA=1, ALUSrcB=00, sub, PCWriteCond=1, PCSource=01.
- JUMP outputs: PCWrite=1, PCSource=10.
- IEXEC outputs: ALUSrcA=1, ALUSrcB=10, ALUOp per opcode (0100/0101/0110/0111). Next state IWB.
- IWB outputs: RegWrite=1, RegDst=0, MemtoReg=0.
- Retirement: MEMWB, MEMWR (with MemReady=1), RWB, BRANCH, JUMP and IWB all return to FETCH and increment InstrCount on that edge.
- Wait counter:
  - In FETCH, MEMRD and MEMWR, a cycle with MemReady=0 increments the counter.
  - The counter clears on any state change.
  - A ready cycle while count<MEM_TIMEOUT proceeds normally. MemReady=1 in the same cycle the limit is reached wins: no trap.
  - When the counter equals MEM_TIMEOUT and MemReady=0, move to TRAP.
- TRAP: all strobes 0, Trap=1. Remains in TRAP until reset.
- Strobes not listed for a state are 0. The x-values of the single-cycle unit are now driven as 0.

## Timing
- State, wait counter and InstrCount are registered. Control outputs are combinational from State, Opcode and MemReady (Mealy in memory states).
- Reset (async): State=FETCH, counters 0, Trap=0. While Reset_n=0, all strobes are forced to 0 and ALUOp=0. First fetch occurs in the cycle after deassertion.
- Zero-wait cycle counts: BEQ/J 3, RTYPE/SW/I-type 4, LW 5. Each wait cycle adds 1.
- Reset mid-instruction: abandons the instruction with no write strobe afterwards and does not increment InstrCount.

## Test plan
- Reset, then RTYPE with MemReady=1 constant: states 0,1,6,7,0. RegWrite=1 only in RWB with RegDst=1. InstrCount=1.
- LW with 2 wait cycles in MEMRD: states 0,1,2,3,3,3,4,0 (8 cycles). MemRead=1 held throughout MEMRD.
- Sequence BEQ, J, ORI: PCWriteCond pulses once, PCWrite pulses in JUMP. IEXEC ALUOp=0111. InstrCount=3.
- Opcode 111111: DECODE→TRAP, Trap=1, strobes 0 for 20 cycles. Reset_n low clears Trap.
- MEM_TIMEOUT=3, MemReady held 0 in FETCH: TRAP after 4 cycles. Repeat with MemReady=1 on the 4th cycle: DECODE, no trap.
- CNT_WIDTH=2: retire 5 instructions → InstrCount=1 (wrap). Reset_n pulse during MEMWR → no MemWrite afterwards, count unchanged.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control
//   Multi-cycle MIPS control unit. A state machine walks each instruction
//   through fetch, decode, execute, memory and write-back cycles on a shared
//   ALU and a unified memory. Memory accesses wait on MemReady. A bounded
//   wait counter traps stalled accesses. The unit also counts retired
//   instructions.
//
// Ports
//   Clk, Reset_n      clock (rising edge), asynchronous active-low reset
//   Opcode[5:0]       Instruction[31:26] from the instruction register
//   MemReady          memory finishes the current read/write this cycle
//   PCWrite .. ALUSrcA  1-bit datapath strobes and mux selects
//   ALUSrcB[1:0]      00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
//   PCSource[1:0]     00 ALU result, 01 ALUOut, 10 jump target
//   ALUOp             0 add, 1 sub, 2 funct, 4 addi, 5 addiu, 6 andi, 7 ori
//   State[3:0]        current state, for debug
//   Trap              illegal opcode or memory timeout (held until reset)
//   InstrCount        retired instructions, wraps
module multicycle_control #(
    parameter int ALUOP_WIDTH = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic [5:0]             Opcode,
    input  logic                   MemReady,
    output logic                   PCWrite,
    output logic                   PCWriteCond,
    output logic                   IorD,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   IRWrite,
    output logic                   MemtoReg,
    output logic                   RegDst,
    output logic                   RegWrite,
    output logic                   ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic [1:0]             PCSource,
    output logic [ALUOP_WIDTH-1:0] ALUOp,
    output logic [3:0]             State,
    output logic                   Trap,
    output logic [CNT_WIDTH-1:0]   InstrCount
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [ALUOP_WIDTH-1:0] ALU_ADD   = ALUOP_WIDTH'(4'b0000);
    localparam logic [ALUOP_WIDTH-1:0] ALU_SUB   = ALUOP_WIDTH'(4'b0001);
    localparam logic [ALUOP_WIDTH-1:0] ALU_FUNCT = ALUOP_WIDTH'(4'b0010);
    localparam logic [ALUOP_WIDTH-1:0] ALU_ADDI  = ALUOP_WIDTH'(4'b0100);
    localparam logic [ALUOP_WIDTH-1:0] ALU_ADDIU = ALUOP_WIDTH'(4'b0101);
    localparam logic [ALUOP_WIDTH-1:0] ALU_ANDI  = ALUOP_WIDTH'(4'b0110);
    localparam logic [ALUOP_WIDTH-1:0] ALU_ORI   = ALUOP_WIDTH'(4'b0111);

    // The wait counter never exceeds MEM_TIMEOUT: reaching it traps.
    localparam int WCW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADDR = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_IEXEC   = 4'd10,
        S_IWB     = 4'd11,
        S_TRAP    = 4'd12
    } state_t;

    state_t         state;
    logic [WCW-1:0] wcnt;
    logic           timeout_hit;

    // A ready cycle wins over the limit, so this is only consulted when
    // MemReady is low.
    assign timeout_hit = (MEM_TIMEOUT != 0) && (wcnt == WCW'(MEM_TIMEOUT));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= S_FETCH;
            wcnt       <= '0;
            InstrCount <= '0;
        end else begin
            // Every state change clears the counter. The wait branches
            // below override this.
            wcnt <= '0;
            case (state)
                S_FETCH: begin
                    if (MemReady)         state <= S_DECODE;
                    else if (timeout_hit) state <= S_TRAP;
                    else                  wcnt  <= wcnt + WCW'(1);
                end
                S_DECODE: begin
                    case (Opcode)
                        OP_LW, OP_SW:                       state <= S_MEMADDR;
                        OP_RTYPE:                           state <= S_EXEC;
                        OP_BEQ:                             state <= S_BRANCH;
                        OP_J:                               state <= S_JUMP;
                        OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI: state <= S_IEXEC;
                        default:                            state <= S_TRAP;
                    endcase
                end
                S_MEMADDR: state <= (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD: begin
                    if (MemReady)         state <= S_MEMWB;
                    else if (timeout_hit) state <= S_TRAP;
                    else                  wcnt  <= wcnt + WCW'(1);
                end
                S_MEMWR: begin
                    if (MemReady) begin
                        state      <= S_FETCH;
                        InstrCount <= InstrCount + CNT_WIDTH'(1);
                    end else if (timeout_hit) begin
                        state <= S_TRAP;
                    end else begin
                        wcnt <= wcnt + WCW'(1);
                    end
                end
                S_EXEC:  state <= S_RWB;
                S_IEXEC: state <= S_IWB;
                S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_IWB: begin
                    state      <= S_FETCH;
                    InstrCount <= InstrCount + CNT_WIDTH'(1);
                end
                S_TRAP:  state <= S_TRAP;
                default: state <= S_TRAP;
            endcase
        end
    end

    // Control decode is combinational from state. It is Mealy on MemReady
    // in FETCH. Reset forces every strobe low, even though the state
    // register already reads FETCH.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        ALUOp       = ALU_ADD;
        if (Reset_n) begin
            case (state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = MemReady;
                    PCWrite = MemReady;
                end
                S_DECODE:  ALUSrcB = 2'b11;
                S_MEMADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALU_FUNCT;
                end
                S_RWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = ALU_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                S_IEXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    case (Opcode)
                        OP_ADDI:  ALUOp = ALU_ADDI;
                        OP_ADDIU: ALUOp = ALU_ADDIU;
                        OP_ANDI:  ALUOp = ALU_ANDI;
                        OP_ORI:   ALUOp = ALU_ORI;
                        default:  ALUOp = ALU_ADD;
                    endcase
                end
                S_IWB:   RegWrite = 1'b1;
                default: ;
            endcase
        end
    end

    assign State = state;
    assign Trap  = Reset_n && (state == S_TRAP);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. It uses a small timeout
// (MEM_TIMEOUT=3) and a 2-bit retired counter, so both the trap and the
// wrap boundaries are reached quickly. Each step pushes its expected state,
// control word, trap and count to a scoreboard. The entry is popped and
// compared on the following falling edge.
module tb_multicycle_control;

    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] JMP   = 6'b000010;
    localparam logic [5:0] ADDI  = 6'b001000;
    localparam logic [5:0] ADDIU = 6'b001001;
    localparam logic [5:0] ANDI  = 6'b001100;
    localparam logic [5:0] ORI   = 6'b001101;
    localparam logic [5:0] ILL   = 6'b111111;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [5:0] Opcode = 6'd0;
    logic       MemReady = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic [3:0] ALUOp, State;
    logic       Trap;
    logic [1:0] InstrCount;

    multicycle_control #(.ALUOP_WIDTH(4), .MEM_TIMEOUT(3), .CNT_WIDTH(2)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Opcode(Opcode), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ALUOp(ALUOp), .State(State), .Trap(Trap), .InstrCount(InstrCount)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [3:0]  st;
        logic [17:0] ctl;
        logic        trap;
        logic [1:0]  cnt;
    } exp_t;

    exp_t        sb[$];
    int          errs = 0;
    int          checks = 0;
    int          step = 0;
    logic [1:0]  exp_cnt = 2'd0;
    logic [17:0] obs_ctl;

    assign obs_ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                      MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp};

    // Expected control word for a state, taken from the output table.
    function automatic logic [17:0] exp_ctl(input logic [3:0] st, input logic [5:0] op,
                                            input logic rdy);
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa;
        logic [1:0] asb, pcs;
        logic [3:0] aop;
        {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, pcs, aop} = 18'd0;
        case (st)
            4'd0:  begin mr = 1; asb = 2'b01; pcw = rdy; irw = rdy; end
            4'd1:  asb = 2'b11;
            4'd2:  begin asa = 1; asb = 2'b10; end
            4'd3:  begin mr = 1; iord = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mw = 1; iord = 1; end
            4'd6:  begin asa = 1; aop = 4'b0010; end
            4'd7:  begin rw = 1; rd = 1; end
            4'd8:  begin asa = 1; aop = 4'b0001; pcwc = 1; pcs = 2'b01; end
            4'd9:  begin pcw = 1; pcs = 2'b10; end
            4'd10: begin
                asa = 1; asb = 2'b10;
                aop = (op == ADDI) ? 4'b0100 : (op == ADDIU) ? 4'b0101 :
                      (op == ANDI) ? 4'b0110 : 4'b0111;
            end
            4'd11: rw = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, pcs, aop};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step, obs, exp);
        end
    endtask

    // One clock cycle: drive, push the expectation, compare on the falling
    // edge. If ret is set, the count goes up on the following rising edge.
    task automatic tick(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                        input bit ret);
        exp_t e;
        Opcode   = op;
        MemReady = rdy;
        e.st   = Reset_n ? st : 4'd0;
        e.ctl  = Reset_n ? exp_ctl(st, op, rdy) : 18'd0;
        e.trap = Reset_n && (st == 4'd12);
        e.cnt  = exp_cnt;
        sb.push_back(e);
        @(negedge Clk);
        e = sb.pop_front();
        chk("state", 32'(State), 32'(e.st));
        chk("ctl",   32'(obs_ctl), 32'(e.ctl));
        chk("trap",  32'(Trap), 32'(e.trap));
        chk("count", 32'(InstrCount), 32'(e.cnt));
        step++;
        @(posedge Clk);
        if (ret) exp_cnt = exp_cnt + 2'd1;
        #1;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        exp_cnt = 2'd0;
        tick(RTYPE, 1'b1, 4'd0, 0);
        tick(SW, 1'b0, 4'd0, 0);
        Reset_n = 1'b1;
    endtask

    // A whole legal instruction. fw = fetch wait cycles, mw = memory wait cycles.
    task automatic run(input logic [5:0] op, input int fw, input int mw);
        for (int i = 0; i < fw; i++) tick(op, 1'b0, 4'd0, 0);
        tick(op, 1'b1, 4'd0, 0);
        tick(op, 1'b1, 4'd1, 0);
        case (op)
            RTYPE: begin tick(op, 1'b1, 4'd6, 0); tick(op, 1'b1, 4'd7, 1); end
            LW: begin
                tick(op, 1'b1, 4'd2, 0);
                for (int i = 0; i < mw; i++) tick(op, 1'b0, 4'd3, 0);
                tick(op, 1'b1, 4'd3, 0);
                tick(op, 1'b1, 4'd4, 1);
            end
            SW: begin
                tick(op, 1'b1, 4'd2, 0);
                for (int i = 0; i < mw; i++) tick(op, 1'b0, 4'd5, 0);
                tick(op, 1'b1, 4'd5, 1);
            end
            BEQ: tick(op, 1'b1, 4'd8, 1);
            JMP: tick(op, 1'b1, 4'd9, 1);
            default: begin tick(op, 1'b1, 4'd10, 0); tick(op, 1'b0, 4'd11, 1); end
        endcase
    endtask

    task automatic hold_trap(input int n);
        for (int i = 0; i < n; i++) tick(6'(i * 7), 1'(i), 4'd12, 0);
    endtask

    initial begin
        @(posedge Clk);
        #1;
        do_reset();
        run(RTYPE, 0, 0);          // count 1
        run(LW, 0, 2);             // count 2
        run(BEQ, 0, 0);            // 3
        run(JMP, 0, 0);            // 0 (wrap)
        run(ORI, 0, 0);            // 1
        run(SW, 1, 1);             // 2
        run(ADDI, 0, 0);           // 3
        run(ADDIU, 2, 0);          // 0
        run(ANDI, 0, 0);           // 1
        run(JMP, 3, 0);            // ready on the cycle the limit is reached: 2
        run(LW, 0, 3);             // memory wait at the limit boundary: 3
        run(BEQ, 0, 0);            // 0
        // Reset while MEMWR is waiting: nothing retires, no write afterwards.
        tick(SW, 1'b1, 4'd0, 0);
        tick(SW, 1'b1, 4'd1, 0);
        tick(SW, 1'b1, 4'd2, 0);
        tick(SW, 1'b0, 4'd5, 0);
        do_reset();
        run(RTYPE, 0, 0);          // 1
        // Illegal opcode traps from DECODE and sticks.
        tick(ILL, 1'b1, 4'd0, 0);
        tick(ILL, 1'b1, 4'd1, 0);
        hold_trap(20);
        do_reset();
        // Fetch timeout: four not-ready cycles, then TRAP.
        for (int i = 0; i < 4; i++) tick(RTYPE, 1'b0, 4'd0, 0);
        hold_trap(5);
        do_reset();
        // Read timeout in MEMRD.
        tick(LW, 1'b1, 4'd0, 0);
        tick(LW, 1'b1, 4'd1, 0);
        tick(LW, 1'b1, 4'd2, 0);
        for (int i = 0; i < 4; i++) tick(LW, 1'b0, 4'd3, 0);
        hold_trap(3);
        // Write timeout in MEMWR.
        do_reset();
        tick(SW, 1'b1, 4'd0, 0);
        tick(SW, 1'b1, 4'd1, 0);
        tick(SW, 1'b1, 4'd2, 0);
        for (int i = 0; i < 4; i++) tick(SW, 1'b0, 4'd5, 0);
        hold_trap(3);
        do_reset();
        run(ORI, 0, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
